// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Holds the FSM state encoding, the legal WIDTH range and a counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // The iteration counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_array_multiplier_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// The same block is used for operand magnitudes and for the product sign fix-up.
module cond_negate #(
  parameter int N = 8
) (
  input  logic         neg,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier with a valid/ready handshake on both sides.
// Signed products are formed from operand magnitudes, and the sign is fixed up on the last iteration.
module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("seq_array_multiplier: WIDTH must lie in 2..32");
  end

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] add_term;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] acc_fix;

  // A WIDTH-bit unsigned register holds |-2^(WIDTH-1)| exactly, so no extra magnitude bit is needed.
  cond_negate #(.N(WIDTH)) u_abs_a (
    .neg (signed_mode & a[WIDTH-1]),
    .x   (a),
    .y   (a_mag)
  );

  cond_negate #(.N(WIDTH)) u_abs_b (
    .neg (signed_mode & b[WIDTH-1]),
    .x   (b),
    .y   (b_mag)
  );

  always_comb begin
    add_term = '0;
    if (mplier[0]) begin
      add_term = mcand << cnt;
    end
    acc_next = acc + add_term;
  end

  cond_negate #(.N(2*WIDTH)) u_fixup (
    .neg (neg),
    .x   (acc_next),
    .y   (acc_fix)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            p     <= acc_fix;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
